// File: rtl/pbvi_loop_ctrl.sv
// PBVI backup-loop controller: captures argmax results, checks convergence, re-kicks or finishes.
// Optional watchdog on the WAIT state is enabled by defining PBVI_WATCHDOG_EN.
module pbvi_loop_ctrl #(
  parameter int          NPTS       = 16,
  parameter int unsigned EPS        = 4,
  parameter int unsigned MAX_ITER   = 32,
  parameter logic [15:0] INIT_ALPHA = 16'd0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       en_loop,
  input  logic [NPTS-1:0][1:0]       point_action,
  input  logic [NPTS-1:0][1:0][15:0] alpha,
  output logic                       en_iter,
  output logic [NPTS-1:0][1:0][15:0] alpha_prev,
  output logic [NPTS-1:0][1:0]       policy,
  output logic [7:0]                 iter_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic                       wd_err
);

  localparam int KW = $clog2(NPTS);
  localparam logic [KW-1:0] K_LAST   = KW'(NPTS - 1);
  localparam logic [15:0]   EPS_W    = 16'(EPS);
  localparam logic [7:0]    LAST_CNT = 8'(MAX_ITER - 1);

  typedef enum logic [2:0] {IDLE, KICK, WAIT, COMPARE, UPDATE, DONE} state_t;

  state_t                       state;
  logic [NPTS-1:0][1:0][15:0]   cap_alpha;
  logic [NPTS-1:0][1:0]         cap_action;
  logic [KW-1:0]                k;
  logic [15:0]                  maxd;
  logic [15:0]                  d0;
  logic [15:0]                  d1;
  logic [15:0]                  step_max;

`ifdef PBVI_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_cnt;
`else
  assign wd_err = 1'b0;
`endif

  function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // One point per COMPARE cycle; running maximum over both components.
  always_comb begin
    d0 = abs_diff(cap_alpha[k][0], alpha_prev[k][0]);
    d1 = abs_diff(cap_alpha[k][1], alpha_prev[k][1]);
    step_max = maxd;
    if (d0 > step_max) step_max = d0;
    if (d1 > step_max) step_max = d1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en_iter    <= 1'b0;
      alpha_prev <= {(2 * NPTS){INIT_ALPHA}};
      policy     <= '0;
      iter_cnt   <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      cap_alpha  <= '0;
      cap_action <= '0;
      k          <= '0;
      maxd       <= 16'd0;
`ifdef PBVI_WATCHDOG_EN
      wd_err     <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            alpha_prev <= {(2 * NPTS){INIT_ALPHA}};
            policy     <= '0;
            iter_cnt   <= 8'd0;
            done       <= 1'b0;
            converged  <= 1'b0;
`ifdef PBVI_WATCHDOG_EN
            wd_err     <= 1'b0;
`endif
            busy       <= 1'b1;
            en_iter    <= 1'b1;
            state      <= KICK;
          end
        end
        KICK: begin
          en_iter <= 1'b0;
`ifdef PBVI_WATCHDOG_EN
          wd_cnt  <= '0;
`endif
          state   <= WAIT;
        end
        WAIT: begin
          if (en_loop) begin
            cap_alpha  <= alpha;
            cap_action <= point_action;
            maxd       <= 16'd0;
            k          <= '0;
            state      <= COMPARE;
          end
`ifdef PBVI_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            wd_err    <= 1'b1;
            done      <= 1'b1;
            converged <= 1'b0;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        COMPARE: begin
          maxd <= step_max;
          k    <= k + 1'b1;
          if (k == K_LAST) state <= UPDATE;
        end
        UPDATE: begin
          alpha_prev <= cap_alpha;
          policy     <= cap_action;
          iter_cnt   <= iter_cnt + 8'd1;
          // The first iteration is compared against INIT_ALPHA and must never count as converged.
          if ((iter_cnt != 8'd0) && (maxd <= EPS_W)) begin
            done      <= 1'b1;
            converged <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else if (iter_cnt == LAST_CNT) begin
            done      <= 1'b1;
            converged <= 1'b0;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            en_iter <= 1'b1;
            state   <= KICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_loop_ctrl.sv
// Self-checking bench for pbvi_loop_ctrl: transaction-level model plus hand-computed literal checks.
module tb_pbvi_loop_ctrl;

  localparam int NPTS     = 16;
  localparam int EPS      = 4;
  localparam int MAX_ITER = 4;
  localparam int TIMEOUT  = 50;

  typedef logic [NPTS-1:0][1:0][15:0] alpha_t;
  typedef logic [NPTS-1:0][1:0]       act_t;

  logic   clk;
  logic   rst_n;
  logic   start;
  logic   en_loop;
  act_t   point_action;
  alpha_t alpha;
  logic   en_iter;
  alpha_t alpha_prev;
  act_t   policy;
  logic [7:0] iter_cnt;
  logic   busy;
  logic   done;
  logic   converged;
  logic   wd_err;

  pbvi_loop_ctrl #(
    .NPTS(NPTS), .EPS(EPS), .MAX_ITER(MAX_ITER), .INIT_ALPHA(16'd0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en_loop(en_loop),
    .point_action(point_action), .alpha(alpha), .en_iter(en_iter),
    .alpha_prev(alpha_prev), .policy(policy), .iter_cnt(iter_cnt),
    .busy(busy), .done(done), .converged(converged), .wd_err(wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_kicks  = 0;

  // Expected visible outputs plus one pending future change and the expected kick window.
  alpha_t m_alpha;
  act_t   m_policy;
  int     m_iter;
  bit     m_busy, m_done, m_conv, m_wd;
  int     kick_win, wd_win;
  bit     p_valid;
  int     p_win;
  alpha_t p_alpha;
  act_t   p_policy;
  int     p_iter;
  bit     p_busy, p_done, p_conv, p_wd;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic alpha_t fill(input logic [15:0] v);
    alpha_t r;
    for (int i = 0; i < NPTS; i++)
      for (int j = 0; j < 2; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic act_t fill_act(input logic [1:0] a);
    act_t r;
    for (int i = 0; i < NPTS; i++) r[i] = a;
    return r;
  endfunction

  function automatic int max_abs_diff(input alpha_t a, input alpha_t b);
    int m = 0;
    for (int i = 0; i < NPTS; i++)
      for (int j = 0; j < 2; j++) begin
        int x = int'(a[i][j]);
        int y = int'(b[i][j]);
        int d = (x > y) ? x - y : y - x;
        if (d > m) m = d;
      end
    return m;
  endfunction

  task automatic model_reset();
    m_alpha  = fill(16'd0);
    m_policy = '0;
    m_iter   = 0;
    m_busy   = 0; m_done = 0; m_conv = 0; m_wd = 0;
    kick_win = -1; wd_win = -1;
    p_valid  = 0;
  endtask

  task automatic model_start(input int w);
    p_valid = 1; p_win = w + 1;
    p_alpha = fill(16'd0); p_policy = '0; p_iter = 0;
    p_busy = 1; p_done = 0; p_conv = 0; p_wd = 0;
    kick_win = w + 1;
    wd_win = w + 2 + TIMEOUT;
  endtask

  // Result accepted in window w becomes visible 18 windows later.
  task automatic model_loop(input int w, input alpha_t a, input act_t p);
    int  md;
    bit  conv, stop;
    md   = max_abs_diff(a, m_alpha);
    conv = (m_iter >= 1) && (md <= EPS);
    stop = conv || (m_iter + 1 == MAX_ITER);
    wd_win = -1;
    p_valid = 1; p_win = w + 18;
    p_alpha = a; p_policy = p; p_iter = m_iter + 1;
    p_busy = !stop; p_done = stop; p_conv = conv; p_wd = m_wd;
    if (!stop) begin
      kick_win = w + 18;
      wd_win   = w + 19 + TIMEOUT;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (p_valid && cyc == p_win) begin
        m_alpha = p_alpha; m_policy = p_policy; m_iter = p_iter;
        m_busy = p_busy; m_done = p_done; m_conv = p_conv; m_wd = p_wd;
        p_valid = 0;
      end
`ifdef PBVI_WATCHDOG_EN
      if (cyc == wd_win) begin
        m_done = 1; m_conv = 0; m_wd = 1; m_busy = 0;
      end
`endif
      checkOutput("en_iter", en_iter, (cyc == kick_win));
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, m_done);
      checkOutput("converged", converged, m_conv);
      checkOutput("wd_err", wd_err, m_wd);
      checkOutput("iter_cnt", iter_cnt, 8'(m_iter));
      checkOutput("policy", policy, m_policy);
      checkOutput("alpha_prev", alpha_prev, m_alpha);
      if (en_iter) n_kicks++;
    end
  end

  task automatic apply_start();
    start = 1'b1;
    model_start(cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_kick(output int w);
    w = -1;
    for (int i = 0; i < 200; i++) begin
      if (en_iter) begin
        w = cyc;
        break;
      end
      @(negedge clk);
    end
    if (w < 0) checkOutput("kick_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done(output int w);
    w = -1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        w = cyc;
        break;
      end
      @(negedge clk);
    end
    if (w < 0) checkOutput("done_timeout", 1'b0, 1'b1);
  endtask

  // Answer the next en_iter with one en_loop pulse two cycles later.
  task automatic applyStimulus(input alpha_t a, input act_t p, output int kw, output int lw);
    wait_kick(kw);
    repeat (2) @(negedge clk);
    en_loop = 1'b1; alpha = a; point_action = p;
    lw = cyc;
    model_loop(lw, a, p);
    @(negedge clk);
    en_loop = 1'b0; alpha = ~a; point_action = ~p;
  endtask

  initial begin
    int kw, lw, kw2, lw2, dw, base;
    alpha_t a2;
    rst_n = 1'b0; start = 1'b0; en_loop = 1'b0;
    alpha = '0; point_action = '0;
    model_reset();

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("reset_alpha_prev", alpha_prev, 512'd0);
    checkOutput("reset_busy_done", {busy, done, converged, wd_err, en_iter}, 5'd0);
    checkOutput("reset_no_kick", n_kicks, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Convergence at iteration 2, with latency and ignore rules
    apply_start();
    applyStimulus(fill(16'd100), fill_act(2'b01), kw, lw);
    applyStimulus(fill(16'd100), fill_act(2'b01), kw2, lw2);
    checkOutput("loop_to_kick_latency", kw2 - lw, 18);
    repeat (4) @(negedge clk);
    en_loop = 1'b1; alpha = fill(16'd7);
    @(negedge clk);
    en_loop = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dw);
    checkOutput("loop_to_done_latency", dw - lw2, 18);
    checkOutput("conv2_converged", converged, 1'b1);
    checkOutput("conv2_iter_cnt", iter_cnt, 8'd2);
    checkOutput("conv2_policy", policy, fill_act(2'b01));
    checkOutput("conv2_alpha_prev", alpha_prev, fill(16'd100));
    repeat (3) @(negedge clk);

    // EPS boundary: +4 converges
    apply_start();
    applyStimulus(fill(16'd100), fill_act(2'b10), kw, lw);
    a2 = fill(16'd100); a2[3][1] = 16'd104;
    applyStimulus(a2, fill_act(2'b10), kw, lw);
    wait_done(dw);
    checkOutput("eps4_converged", converged, 1'b1);
    checkOutput("eps4_iter_cnt", iter_cnt, 8'd2);
    repeat (3) @(negedge clk);

    // EPS boundary: +5 forces a third iteration
    apply_start();
    applyStimulus(fill(16'd100), fill_act(2'b11), kw, lw);
    a2 = fill(16'd100); a2[3][1] = 16'd105;
    applyStimulus(a2, fill_act(2'b11), kw, lw);
    applyStimulus(a2, fill_act(2'b11), kw2, lw2);
    checkOutput("eps5_third_kick", kw2 - lw, 18);
    wait_done(dw);
    checkOutput("eps5_iter_cnt", iter_cnt, 8'd3);
    checkOutput("eps5_converged", converged, 1'b1);
    repeat (3) @(negedge clk);

    // MAX_ITER stop with alternating data
    base = n_kicks;
    apply_start();
    applyStimulus(fill(16'd0),    fill_act(2'b10), kw, lw);
    applyStimulus(fill(16'd1000), fill_act(2'b11), kw, lw);
    applyStimulus(fill(16'd0),    fill_act(2'b10), kw, lw);
    applyStimulus(fill(16'd1000), fill_act(2'b11), kw, lw);
    wait_done(dw);
    repeat (5) @(negedge clk);
    checkOutput("maxit_converged", converged, 1'b0);
    checkOutput("maxit_iter_cnt", iter_cnt, 8'd4);
    checkOutput("maxit_kicks", n_kicks - base, 4);
    checkOutput("maxit_alpha_prev", alpha_prev, fill(16'd1000));

    // Reset during COMPARE k=7
    apply_start();
    applyStimulus(fill(16'd100), fill_act(2'b01), kw, lw);
    applyStimulus(fill(16'd500), fill_act(2'b10), kw, lw);
    repeat (7) @(negedge clk);
    checkOutput("pre_abort_alpha_prev", alpha_prev, fill(16'd100));
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("abort_alpha_prev", alpha_prev, 512'd0);
    checkOutput("abort_iter_cnt", iter_cnt, 8'd0);
    checkOutput("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Waiting with no en_loop
    apply_start();
    wait_kick(kw);
`ifdef PBVI_WATCHDOG_EN
    wait_done(dw);
    checkOutput("wd_fire_window", dw - kw, 1 + TIMEOUT);
    checkOutput("wd_flags", {wd_err, done, converged}, 3'b110);
`else
    repeat (80) @(negedge clk);
    checkOutput("wait_forever_flags", {busy, done, wd_err}, 3'b100);
`endif
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
